// File: rtl/opl3_sample_capture_if.sv
// opl3_sample_capture_if: published left/right sample pair with valid/ready handshake.
interface opl3_sample_capture_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] smp_left, smp_right;
  logic smp_valid, smp_ready;
  modport master (output smp_left, smp_right, smp_valid, input smp_ready);
  modport slave (input smp_left, smp_right, smp_valid, output smp_ready);
endinterface

// File: rtl/opl3_sample_capture.sv
// opl3_sample_capture: recovers YMF262 serial audio on clk28 and publishes left/right pairs.
// Define OPL3_CAP_WDOG_EN to add the ym_dclk stall watchdog.
module opl3_sample_capture #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk28,
  input  logic n_rst,
  input  logic ym_dclk,
  input  logic [2:1] ym_smp,
  input  logic ym_data,
  input  logic clr_flags,
  opl3_sample_capture_if.master bus,
  output logic overrun,
  output logic short_frame,
  output logic sync_err,
  output logic stall
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} cap_state_t;
  if (SYNC_STAGES < 2 || WDOG_CYCLES < 2) begin : g_bad_param
    $error("SYNC_STAGES and WDOG_CYCLES must be >= 2");
  end
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic dclk_h, ev, trip, left_fresh, fresh_now, pub;
  logic [2:1] done, short_ev, smp_last;
  cap_state_t st [1:2];
  logic [CW-1:0] cnt [1:2];
  logic [WIDTH-1:0] sr [1:2];
  logic [WIDTH-1:0] hold_l;
  // s = {data, smp[2:1], dclk}, all taken from the same synchroniser stage
  always_ff @(posedge clk28) begin
    if (!n_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dclk_h <= 1'b0;
    end else begin
      sync_q[0] <= {ym_data, ym_smp, ym_dclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dclk_h <= s[0];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];
  assign ev = s[0] & ~dclk_h;
  for (genvar c = 1; c <= 2; c++) begin : g_ch
    assign done[c] = st[c] == SHIFT && cnt[c] == FULL;
    assign short_ev[c] = ev && st[c] == SHIFT && !done[c] && !s[c];
  end
  assign fresh_now = left_fresh | done[1];
  assign pub = done[2] && fresh_now && !trip;
  always_ff @(posedge clk28) begin
    if (!n_rst) begin
      for (int c = 1; c <= 2; c++) begin
        st[c] <= IDLE;
        cnt[c] <= '0;
        sr[c] <= '0;
      end
      smp_last <= '0;
      hold_l <= '0;
      left_fresh <= 1'b0;
      bus.smp_left <= '0;
      bus.smp_right <= '0;
      bus.smp_valid <= 1'b0;
      overrun <= 1'b0;
      short_frame <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (ev) smp_last <= s[2:1];
      for (int c = 1; c <= 2; c++) begin
        if (trip) st[c] <= IDLE;
        else if (done[c]) st[c] <= DONE;
        else if (ev && st[c] == IDLE && s[c] && !smp_last[c]) begin
          sr[c] <= {s[3], sr[c][WIDTH-1:1]};
          cnt[c] <= CW'(1);
          st[c] <= SHIFT;
        end else if (ev && st[c] == SHIFT && s[c]) begin
          sr[c] <= {s[3], sr[c][WIDTH-1:1]};
          cnt[c] <= cnt[c] + CW'(1);
        end else if (ev && st[c] != IDLE && !s[c]) st[c] <= IDLE;
      end
      if (done[1]) hold_l <= sr[1];
      left_fresh <= fresh_now && !pub && !trip;
      // right completion publishes straight from its shift register
      if (trip) begin
        bus.smp_left <= '0;
        bus.smp_right <= '0;
        bus.smp_valid <= 1'b0;
      end else if (pub) begin
        bus.smp_left <= done[1] ? sr[1] : hold_l;
        bus.smp_right <= sr[2];
        bus.smp_valid <= 1'b1;
      end else if (bus.smp_ready) bus.smp_valid <= 1'b0;
      overrun <= (pub && bus.smp_valid && !bus.smp_ready) || (overrun && !clr_flags);
      short_frame <= (|short_ev) || (short_frame && !clr_flags);
      sync_err <= (done[2] && !fresh_now) || (sync_err && !clr_flags);
    end
  end
`ifdef OPL3_CAP_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WLIM = WW'(WDOG_CYCLES);
  logic [WW-1:0] wd;
  assign trip = !ev && wd == WLIM - WW'(1);
  always_ff @(posedge clk28) begin
    if (!n_rst) begin
      wd <= '0;
      stall <= 1'b0;
    end else begin
      wd <= ev ? '0 : (wd == WLIM ? wd : wd + WW'(1));
      stall <= !ev && (trip || stall);
    end
  end
`else
  assign trip = 1'b0;
  assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_opl3_sample_capture.sv
// tb_opl3_sample_capture: directed frames with a pair scoreboard for opl3_sample_capture.
module tb_opl3_sample_capture;
  logic clk28 = 1'b0;
  logic n_rst = 1'b0;
  logic ym_dclk = 1'b0;
  logic [2:1] ym_smp = 2'b00;
  logic ym_data = 1'b0;
  logic clr_flags = 1'b0;
  logic overrun, short_frame, sync_err, stall;
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int exp_acc = 0;
  logic [31:0] sb [$];
  opl3_sample_capture_if #(.WIDTH(16)) smp ();
  opl3_sample_capture dut (
    .clk28(clk28), .n_rst(n_rst), .ym_dclk(ym_dclk), .ym_smp(ym_smp),
    .ym_data(ym_data), .clr_flags(clr_flags), .bus(smp),
    .overrun(overrun), .short_frame(short_frame), .sync_err(sync_err), .stall(stall)
  );
  always #18 clk28 = ~clk28;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // acceptance happens at the next rise whenever valid&ready holds mid-cycle
  always @(negedge clk28) begin
    if (n_rst && smp.smp_valid && smp.smp_ready) begin
      logic [31:0] e;
      accepted++;
      chk("pair_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pair_left", 32'(smp.smp_left), 32'(e[31:16]));
        chk("pair_right", 32'(smp.smp_right), 32'(e[15:0]));
      end
    end
  end
  task automatic bit_rise(input logic d, input logic [2:1] m);
    @(negedge clk28);
    ym_data = d;
    ym_smp = m;
    repeat (8) @(negedge clk28);
    ym_dclk = 1'b1;
  endtask
  task automatic bit_fall;
    repeat (9) @(negedge clk28);
    ym_dclk = 1'b0;
  endtask
  task automatic send_word(input logic [2:1] m, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_rise(w[i], m);
      bit_fall();
    end
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit lat);
    send_word(2'b01, l, 16);
    send_word(2'b10, r, 15);
    bit_rise(r[15], 2'b10);
    if (lat) begin
      repeat (3) @(posedge clk28);
      #1 chk("latency_early", 32'(smp.smp_valid), 32'd0);
      @(posedge clk28);
      #1 chk("latency_valid", 32'(smp.smp_valid), 32'd1);
    end
    bit_fall();
    bit_rise(1'b0, 2'b00);
    bit_fall();
  endtask
  task automatic pulse_clr;
    @(negedge clk28) clr_flags = 1'b1;
    @(negedge clk28) clr_flags = 1'b0;
  endtask
  initial begin
    smp.smp_ready = 1'b1;
    repeat (4) @(negedge clk28) begin
      ym_dclk = ~ym_dclk;
      ym_smp = ~ym_smp;
      ym_data = ~ym_data;
    end
    chk("rst_left", 32'(smp.smp_left), 32'd0);
    chk("rst_right", 32'(smp.smp_right), 32'd0);
    chk("rst_valid", 32'(smp.smp_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_short", 32'(short_frame), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    ym_dclk = 1'b0;
    ym_smp = 2'b00;
    ym_data = 1'b0;
    @(negedge clk28) n_rst = 1'b1;
    repeat (3) @(negedge clk28);
    sb.push_back({16'h1234, 16'hABCD});
    exp_acc++;
    send_frame(16'h1234, 16'hABCD, 1'b1);
    chk("basic_accepted", 32'(accepted), 32'(exp_acc));
    chk("basic_flags", {29'd0, overrun, short_frame, sync_err}, 32'd0);
    @(posedge clk28) #1 smp.smp_ready = 1'b0;
    send_frame(16'h0001, 16'h0002, 1'b0);
    chk("bp_valid1", 32'(smp.smp_valid), 32'd1);
    chk("bp_no_overrun", 32'(overrun), 32'd0);
    send_frame(16'h0003, 16'h0004, 1'b0);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_left", 32'(smp.smp_left), 32'h0003);
    chk("bp_right", 32'(smp.smp_right), 32'h0004);
    sb.push_back({16'h0003, 16'h0004});
    exp_acc++;
    @(posedge clk28) #1 smp.smp_ready = 1'b1;
    repeat (2) @(posedge clk28);
    #1 chk("bp_valid_drop", 32'(smp.smp_valid), 32'd0);
    pulse_clr();
    chk("bp_overrun_clr", 32'(overrun), 32'd0);
    send_word(2'b01, 16'hFFFF, 10);
    send_word(2'b10, 16'h0F0F, 16);
    bit_rise(1'b0, 2'b00);
    bit_fall();
    chk("short_flag", 32'(short_frame), 32'd1);
    chk("short_sync", 32'(sync_err), 32'd1);
    chk("short_no_valid", 32'(smp.smp_valid), 32'd0);
    pulse_clr();
    chk("short_clr", {30'd0, short_frame, sync_err}, 32'd0);
    send_word(2'b01, 16'h00FF, 8);
    @(negedge clk28) n_rst = 1'b0;
    ym_smp = 2'b00;
    repeat (3) @(negedge clk28);
    n_rst = 1'b1;
    repeat (2) @(negedge clk28);
    chk("midrst_valid", 32'(smp.smp_valid), 32'd0);
    sb.push_back({16'h5555, 16'hAAAA});
    exp_acc++;
    send_frame(16'h5555, 16'hAAAA, 1'b0);
    repeat (4) @(negedge clk28);
    chk("midrst_accepted", 32'(accepted), 32'(exp_acc));
    chk("midrst_flags", {29'd0, overrun, short_frame, sync_err}, 32'd0);
`ifdef OPL3_CAP_WDOG_EN
    @(posedge clk28) #1 smp.smp_ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b0);
    chk("wdog_pending", 32'(smp.smp_valid), 32'd1);
    repeat (1030) @(negedge clk28);
    chk("wdog_stall", 32'(stall), 32'd1);
    chk("wdog_valid", 32'(smp.smp_valid), 32'd0);
    chk("wdog_data", {smp.smp_left, smp.smp_right}, 32'd0);
    @(posedge clk28) #1 smp.smp_ready = 1'b1;
    bit_rise(1'b0, 2'b00);
    repeat (4) @(posedge clk28);
    #1 chk("wdog_unstall", 32'(stall), 32'd0);
    bit_fall();
    sb.push_back({16'h7777, 16'h8888});
    exp_acc++;
    send_frame(16'h7777, 16'h8888, 1'b0);
    repeat (4) @(negedge clk28);
`endif
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_accepted", 32'(accepted), 32'(exp_acc));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
